serial_adder: RTL and testbench

- Parametrised, bit-serial successor to the team's single-bit half-adder cell.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using a registered carry.
- A start/busy/done handshake frames each operation.
- Intended for area-constrained datapaths where a full ripple adder of WIDTH bits is not wanted.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand bus for the bit-serial adder.
// The master drives the request and operands; the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, with a registered carry.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    // One extra counter bit keeps the WIDTH-1 compare from ever wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_S;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shift;
    logic [WIDTH-1:0] w_opA_shift;
    logic [WIDTH-1:0] w_opB_shift;

    serial_adder_fa u_fa (
        .i_a (r_opA[0]),
        .i_b (r_opB[0]),
        .i_c (r_carry),
        .o_s (w_sum_bit),
        .o_c (w_carry_nxt)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_shift = w_sum_bit;
            assign w_opA_shift = 1'b0;
            assign w_opB_shift = 1'b0;
        end else begin : g_wn
            assign w_sum_shift = {w_sum_bit, r_sum[WIDTH-1:1]};
            assign w_opA_shift = {1'b0, r_opA[WIDTH-1:1]};
            assign w_opB_shift = {1'b0, r_opB[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_S     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_opA   <= bus.A;
                    r_opB   <= bus.B;
                    r_carry <= bus.Cin;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_opA   <= w_opA_shift;
                    r_opB   <= w_opB_shift;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    // Result registers only move on completion; they hold through IDLE and the next RUN.
                    if (w_last) begin
                        r_S    <= w_sum_shift;
                        r_cout <= w_carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.S    = r_S;
    assign bus.Cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8, 1 and 64.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  m8 ();
    serial_adder_if #(.WIDTH(1))  m1 ();
    serial_adder_if #(.WIDTH(64)) m64 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(m8.slave));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(m1.slave));
    serial_adder #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(m64.slave));

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] prev_s, input logic prev_c,
                        input logic [7:0] exp_s, input logic exp_c);
        int n;
        m8.start = 1'b1; m8.A = a; m8.B = b; m8.Cin = ci;
        tick();
        m8.start = 1'b0;
        chk({tag, "_hold"}, {m8.Cout, m8.S}, {prev_c, prev_s});
        n = 0;
        while (m8.busy && n < 40) begin n++; tick(); end
        chk({tag, "_busycyc"}, 65'(n), 65'd8);
        chk({tag, "_done"}, m8.done, 1'b1);
        chk({tag, "_busy0"}, m8.busy, 1'b0);
        chk({tag, "_sum"}, {m8.Cout, m8.S}, {exp_c, exp_s});
        tick();
        chk({tag, "_donepulse"}, m8.done, 1'b0);
    endtask

    initial begin
        int n, dcnt, bcnt;
        int unsigned last;
        logic        a1, b1, c1;
        logic [63:0] a64, b64;
        logic        c64;

        rst = 1'b1;
        m8.start = 0;  m8.A = '0;  m8.B = '0;  m8.Cin = 0;
        m1.start = 0;  m1.A = '0;  m1.B = '0;  m1.Cin = 0;
        m64.start = 0; m64.A = '0; m64.B = '0; m64.Cin = 0;
        tick(); tick();
        chk("rst_busy", m8.busy, 1'b0);
        chk("rst_done", m8.done, 1'b0);
        chk("rst_S", m8.S, 8'h00);
        chk("rst_Cout", m8.Cout, 1'b0);
        chk("rst_busy1", m1.busy, 1'b0);
        chk("rst_busy64", m64.busy, 1'b0);
        rst = 1'b0;
        tick();

        run8("basic",  8'h35, 8'h4A, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0);
        run8("chain1", 8'hFF, 8'h00, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b1);
        run8("chain2", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1);

        // start held high and operands changed during RUN and DONE
        m8.start = 1'b1; m8.A = 8'h12; m8.B = 8'h34; m8.Cin = 1'b0;
        tick();
        m8.A = 8'h11; m8.B = 8'h11;
        chk("ign_hold", {m8.Cout, m8.S}, {1'b1, 8'hFF});
        n = 0;
        while (m8.busy && n < 40) begin n++; tick(); end
        chk("ign_busycyc", 65'(n), 65'd8);
        chk("ign_done", m8.done, 1'b1);
        chk("ign_sum", {m8.Cout, m8.S}, {1'b0, 8'h46});
        tick();
        chk("ign_done_start_busy", m8.busy, 1'b0);
        chk("ign_done_start_done", m8.done, 1'b0);
        tick();
        chk("ign_restart_busy", m8.busy, 1'b1);
        chk("ign_restart_hold", {m8.Cout, m8.S}, {1'b0, 8'h46});
        m8.start = 1'b0;
        n = 0;
        while (m8.busy && n < 40) begin n++; tick(); end
        chk("ign_restart_sum", {m8.Cout, m8.S}, {1'b0, 8'h22});
        tick();

        // asynchronous reset between edges during RUN
        m8.start = 1'b1; m8.A = 8'h0F; m8.B = 8'h01; m8.Cin = 1'b0;
        tick();
        m8.start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", m8.busy, 1'b0);
        chk("mid_rst_done", m8.done, 1'b0);
        chk("mid_rst_S", m8.S, 8'h00);
        chk("mid_rst_Cout", m8.Cout, 1'b0);
        tick();
        rst = 1'b0;
        dcnt = 0; bcnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (m8.done) dcnt++;
            if (m8.busy) bcnt++;
        end
        chk("mid_rst_nodone", 65'(dcnt), 65'd0);
        chk("mid_rst_idle", 65'(bcnt), 65'd0);

        // WIDTH=1 back-to-back
        last = 0;
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
            m1.start = 1'b1; m1.A = a1; m1.B = b1; m1.Cin = c1;
            tick();
            m1.start = 1'b0;
            n = 0;
            while (!m1.done && n < 10) begin n++; tick(); end
            chk("w1_lat", 65'(n), 65'd1);
            chk("w1_sum", {m1.Cout, m1.S}, 65'(a1) + 65'(b1) + 65'(c1));
            if (i > 0) chk("w1_spacing", 65'(cyc - last), 65'd3);
            last = cyc;
            tick();
        end

        // WIDTH=64 back-to-back
        for (int i = 0; i < 1000; i++) begin
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = 1'($urandom_range(0, 1));
            m64.start = 1'b1; m64.A = a64; m64.B = b64; m64.Cin = c64;
            tick();
            m64.start = 1'b0;
            n = 0;
            while (!m64.done && n < 80) begin n++; tick(); end
            chk("w64_lat", 65'(n), 65'd64);
            chk("w64_sum", {m64.Cout, m64.S}, 65'(a64) + 65'(b64) + 65'(c64));
            if (i > 0) chk("w64_spacing", 65'(cyc - last), 65'd66);
            last = cyc;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
